// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS main controller:
// state encodings, opcodes, ALUOp classes and the control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore control-word decoder; only FETCH's IR/PC loads
// depend on the memory handshake.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t st,
    input  logic   rdy,
    output ctrl_t  cw
);

    always_comb begin
        cw = '0;
        unique case (st)
            S_DECODE: begin
                cw.alu_src_b = 2'd3;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'd2;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALU_SUB;
                cw.branch    = 1'b1;
                cw.pc_src    = 2'd1;
            end
            S_ADDIWB: cw.reg_write = 1'b1;
            S_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = 2'd2;
            end
            // FETCH, and the unused encodings that alias to it
            default: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = 2'd1;
                cw.alu_op    = ALU_ADD;
                cw.ir_write  = rdy;
                cw.pc_write  = rdy;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state/opcode registers,
// next-state logic and reset gating around the decoder.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal,
    output logic [3:0]         state
);

    state_t     st_q, st_d;
    logic [5:0] op_q;
    logic       rdy;
    ctrl_t      cw;

    assign rdy   = MEM_WAIT ? mem_ready : 1'b1;
    assign state = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= S_FETCH;
        else     st_q <= st_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   op_q <= '0;
        else if (st_q == S_DECODE) op_q <= opcode;
    end

    always_comb begin
        st_d = S_FETCH;
        unique case (st_q)
            S_FETCH: st_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     st_d = S_EXEC;
                    OP_LW, OP_SW: st_d = S_MEMADR;
                    OP_BEQ:       st_d = S_BRANCH;
                    OP_ADDI:      st_d = S_ADDIEX;
                    OP_J:         st_d = S_JUMP;
                    default:      st_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_LW)      st_d = S_MEMRD;
                else if (op_q == OP_SW) st_d = S_MEMWR;
            end
            S_MEMRD:  st_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  st_d = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   st_d = S_ALUWB;
            S_ADDIEX: st_d = S_ADDIWB;
            default:  st_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .st  (st_q),
        .rdy (rdy),
        .cw  (cw)
    );

    // Reset gates every output so no write escapes an aborted instruction.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = '0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        if (!rst) begin
            pc_write   = cw.pc_write;
            branch     = cw.branch;
            iord       = cw.iord;
            mem_read   = cw.mem_read;
            mem_write  = cw.mem_write;
            ir_write   = cw.ir_write;
            reg_dst    = cw.reg_dst;
            mem_to_reg = cw.mem_to_reg;
            reg_write  = cw.reg_write;
            alu_src_a  = cw.alu_src_a;
            alu_src_b  = cw.alu_src_b;
            alu_op     = ALUOP_W'(cw.alu_op);
            pc_src     = cw.pc_src;
            illegal    = (st_q == S_DECODE) && (st_d == S_FETCH);
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS main controller: a registered FSM that sequences each instruction over 3–5 cycles, and stalls on a variable-latency memory handshake. It replaces the single-cycle opcode decoder in the multi-cycle datapath and drives the PC, IR, register-file, memory and ALU-operand muxes. It supports R-type, lw, sw, beq, addi and j, flags illegal opcodes, and has a parametrised ALUOp width.

## Interface
- ALUOP_W, 3: ALUOp width, ≥2. Codes are zero-extended: ADD=0, SUB=1, FUNCT=2.
- MEM_WAIT, 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constantly 1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load if ALU zero.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  write register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write data: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B: 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op  out  ALUOP_W  ALU operation class.
- pc_src  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- state  out  4  current state, for debug.

## Operation
- States and encodings:
  - FETCH 0: mem_read, alu_src_a=0, alu_src_b=1, ADD, pc_src=0. ir_write and pc_write assert only when `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
  - DECODE 1: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other opcode → FETCH, with `illegal` pulsed.
  - MEMADR 2: alu_src_a=1, alu_src_b=2, ADD. Next state: lw → MEMRD, sw → MEMWR. The opcode is held from DECODE in an internal register.
  - MEMRD 3: mem_read, iord=1. Wait for `mem_ready`, then go to MEMWB.
  - MEMWB 4: reg_write, mem_to_reg=1, reg_dst=0. Next state FETCH.
  - MEMWR 5: mem_write, iord=1. Wait for `mem_ready`, then go to FETCH.
  - EXEC 6: alu_src_a=1, alu_src_b=0, FUNCT. Next state ALUWB.
  - ALUWB 7: reg_write, reg_dst=1, mem_to_reg=0. Next state FETCH.
  - BRANCH 8: alu_src_a=1, alu_src_b=0, SUB, branch, pc_src=1. Next state FETCH.
  - ADDIEX 9: alu_src_a=1, alu_src_b=2, ADD. Next state ADDIWB.
  - ADDIWB 10: reg_write, reg_dst=0, mem_to_reg=0. Next state FETCH.
  - JUMP 11: pc_write, pc_src=2. Next state FETCH.
- Encodings 12–15 are unreachable; if entered, they behave as FETCH and the next state is FETCH.
- Any output not listed for a state is 0.
- Outputs are Moore, decoded from `state`. The only exceptions are FETCH's ir_write and pc_write, which are ANDed with `mem_ready`.
- MEM_WAIT=0: every access completes in one cycle.

## Timing
- Reset: `state`=FETCH and the held opcode register = 0, both asynchronously. While `rst` is high, every output except `state` is forced to 0. FETCH is asserted on the first rising edge after `rst` falls.
- Reset mid-instruction aborts the instruction with no partial write. reg_write and mem_write drop in the same cycle `rst` rises.
- Latency with `mem_ready` constantly 1:
  - lw: 5 cycles
  - R-type, addi, sw: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. During the stall the control word is held stable and ir_write/pc_write stay 0.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `illegal` is high for exactly the DECODE cycle.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum with the encodings above
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp codes
  - a packed control-word struct
- One sub-module, `mc_ctrl_decode`: combinational, maps state plus `mem_ready` to the control word.
- Top level contains the state register, the held-opcode register, next-state logic and reset gating.

## Test plan
- Reset release, then R-type with `mem_ready`=1 → states 0,1,6,7,0. reg_write=1 only in cycle 4, with reg_dst=1. alu_op=2 in EXEC.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD → states 0,0,0,1,2,3,3,3,3,4,0. ir_write pulses once, in the third cycle.
- sw then beq → mem_write=1 with iord=1 in MEMWR. BRANCH drives branch=1, alu_op=1, pc_src=1.
- Opcode 6'b111111 → `illegal`=1 in the DECODE cycle, FETCH on the next cycle, no write enables asserted.
- Assert `rst` during MEMWB → reg_write drops in the same cycle. After release, `state`=0 and all outputs follow FETCH values.
- ALUOP_W=4, MEM_WAIT=0, addi → states 0,1,9,10,0 with alu_op=4'b0000 and alu_src_b=2 in ADDIEX. `mem_ready` tied to 0 causes no stall.
